// File: rtl/cache_axi_arbiter.sv
// Arbitrates icache/dcache read misses onto one bridge read channel and buffers
// a single dcache dirty-line writeback, blocking reads to the line in flight.
module cache_axi_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,
    output logic [31:0]  i_ret_data,
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,
    output logic [31:0]  d_ret_data,
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_strb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,
    output logic         rd_req,
    output logic [2:0]   rd_type,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data,
    output logic         wr_req,
    output logic [2:0]   wr_type,
    output logic [31:0]  wr_addr,
    output logic [3:0]   wr_strb,
    output logic [127:0] wr_data,
    input  logic         wr_rdy,
    input  logic         wr_done,
    output logic [1:0]   dbg_rd_state,
    output logic [1:0]   dbg_wr_state,
    output logic [2:0]   dbg_starve_cnt
);

    // Handshakes: an upstream request is taken in the cycle its *_rd_rdy or
    // d_wr_rdy is high while its req is high; downstream rd_req/wr_req hold
    // their fields stable until the cycle the bridge returns rd_rdy/wr_rdy.

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_REQ = 2'd1, R_DATA = 2'd2} rd_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_REQ = 2'd1, W_WAIT = 2'd2} wr_state_t;

    localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

    rd_state_t    rd_state, rd_next;
    wr_state_t    wr_state, wr_next;
    logic         owner_d;
    logic [2:0]   lat_rd_type;
    logic [31:0]  lat_rd_addr;
    logic [2:0]   starve_cnt;
    logic [2:0]   lat_wr_type;
    logic [31:0]  lat_wr_addr;
    logic [3:0]   lat_wr_strb;
    logic [127:0] lat_wr_data;

    logic wr_accept, wr_busy;
    logic i_haz, d_haz, i_elig, d_elig, i_win, d_win, grant_ok, in_data;

    always_comb begin
        d_wr_rdy  = (wr_state == W_IDLE) && !reset;
        wr_accept = d_wr_req && d_wr_rdy;
        wr_busy   = (wr_state != W_IDLE);
        // A read may not overtake a writeback to the same line, whether it is
        // already buffered or being accepted in this very cycle.
        i_haz = (wr_busy && (i_rd_addr[31:4] == lat_wr_addr[31:4])) ||
                (wr_accept && (i_rd_addr[31:4] == d_wr_addr[31:4]));
        d_haz = (wr_busy && (d_rd_addr[31:4] == lat_wr_addr[31:4])) ||
                (wr_accept && (d_rd_addr[31:4] == d_wr_addr[31:4]));
        i_elig   = i_rd_req && !i_haz;
        d_elig   = d_rd_req && !d_haz;
        i_win    = i_elig && (!d_elig || (starve_cnt == LIMIT));
        d_win    = d_elig && !i_win;
        grant_ok = (rd_state == R_IDLE) && !reset;
        i_rd_rdy = grant_ok && i_win;
        d_rd_rdy = grant_ok && d_win;
    end

    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            R_IDLE:  if (i_rd_rdy || d_rd_rdy) rd_next = R_REQ;
            R_REQ:   if (rd_rdy) rd_next = R_DATA;
            R_DATA:  if (ret_valid && ret_last) rd_next = R_IDLE;
            default: rd_next = R_IDLE;
        endcase
    end

    always_comb begin
        rd_req  = (rd_state == R_REQ);
        rd_type = lat_rd_type;
        rd_addr = lat_rd_addr;
        in_data = (rd_state == R_DATA);
        i_ret_valid = in_data && !owner_d && ret_valid;
        i_ret_last  = in_data && !owner_d && ret_last;
        i_ret_data  = (in_data && !owner_d) ? ret_data : 32'd0;
        d_ret_valid = in_data && owner_d && ret_valid;
        d_ret_last  = in_data && owner_d && ret_last;
        d_ret_data  = (in_data && owner_d) ? ret_data : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state    <= R_IDLE;
            owner_d     <= 1'b0;
            lat_rd_type <= 3'd0;
            lat_rd_addr <= 32'd0;
            starve_cnt  <= 3'd0;
        end else begin
            rd_state <= rd_next;
            if (i_rd_rdy) begin
                owner_d     <= 1'b0;
                lat_rd_type <= i_rd_type;
                lat_rd_addr <= i_rd_addr;
            end else if (d_rd_rdy) begin
                owner_d     <= 1'b1;
                lat_rd_type <= d_rd_type;
                lat_rd_addr <= d_rd_addr;
            end
            // Count only dcache wins that actually kept an eligible icache waiting.
            if (i_rd_rdy)
                starve_cnt <= 3'd0;
            else if (d_rd_rdy && i_elig && (starve_cnt != LIMIT))
                starve_cnt <= starve_cnt + 3'd1;
        end
    end

    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            W_IDLE:  if (wr_accept) wr_next = W_REQ;
            W_REQ:   if (wr_rdy) wr_next = W_WAIT;
            W_WAIT:  if (wr_done) wr_next = W_IDLE;
            default: wr_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state    <= W_IDLE;
            lat_wr_type <= 3'd0;
            lat_wr_addr <= 32'd0;
            lat_wr_strb <= 4'd0;
            lat_wr_data <= 128'd0;
        end else begin
            wr_state <= wr_next;
            if (wr_accept) begin
                lat_wr_type <= d_wr_type;
                lat_wr_addr <= d_wr_addr;
                lat_wr_strb <= d_wr_strb;
                lat_wr_data <= d_wr_data;
            end
        end
    end

    always_comb begin
        wr_req  = (wr_state == W_REQ);
        wr_type = lat_wr_type;
        wr_addr = lat_wr_addr;
        wr_strb = lat_wr_strb;
        wr_data = lat_wr_data;
        dbg_rd_state   = rd_state;
        dbg_wr_state   = wr_state;
        dbg_starve_cnt = starve_cnt;
    end

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// Directed bench for cache_axi_arbiter: grant/return path, starvation order,
// writeback hazard, back-pressure and mid-transfer reset.
module tb_cache_axi_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_rd_req, d_rd_req, d_wr_req;
    logic [2:0]   i_rd_type, d_rd_type, d_wr_type;
    logic [31:0]  i_rd_addr, d_rd_addr, d_wr_addr;
    logic [3:0]   d_wr_strb;
    logic [127:0] d_wr_data;
    logic         i_rd_rdy, d_rd_rdy, d_wr_rdy;
    logic         i_ret_valid, i_ret_last, d_ret_valid, d_ret_last;
    logic [31:0]  i_ret_data, d_ret_data;
    logic         rd_req, rd_rdy, ret_valid, ret_last, wr_req, wr_rdy, wr_done;
    logic [2:0]   rd_type, wr_type;
    logic [31:0]  rd_addr, ret_data, wr_addr;
    logic [3:0]   wr_strb;
    logic [127:0] wr_data;
    logic [1:0]   dbg_rd_state, dbg_wr_state;
    logic [2:0]   dbg_starve_cnt;

    int errors = 0;
    int checks = 0;

    logic exp_i  [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   exp_cnt[10] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};

    cache_axi_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
        .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
        .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_strb(d_wr_strb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_strb(wr_strb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done),
        .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state), .dbg_starve_cnt(dbg_starve_cnt)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1, "watchdog");
    end

    // driver: after a grant cycle, drop requests, accept the read, return one last beat
    task automatic complete_read(input logic [31:0] data);
        @(negedge clk);
        i_rd_req = 1'b0; d_rd_req = 1'b0; rd_rdy = 1'b1;
        @(negedge clk);
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = data;
        @(negedge clk);
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({i_rd_rdy, d_rd_rdy, d_wr_rdy, rd_req, wr_req} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b want 00000", {i_rd_rdy, d_rd_rdy, d_wr_rdy, rd_req, wr_req});
        end
        checks++;
        if ({i_ret_valid, d_ret_valid, i_ret_data, d_ret_data, rd_addr, wr_addr} !== '0) begin
            errors++; $display("FAIL reset_data: got nonzero outputs, want all 0");
        end
        checks++;
        if ({dbg_rd_state, dbg_wr_state, dbg_starve_cnt} !== 7'd0) begin
            errors++; $display("FAIL reset_state: got %b want 0", {dbg_rd_state, dbg_wr_state, dbg_starve_cnt});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (d_wr_rdy !== 1'b1) begin
            errors++; $display("FAIL reset_wr_rdy: got %b want 1", d_wr_rdy);
        end
    endtask

    task automatic test_icache_read;
        int beats;
        beats = 0;
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h1C00_0010; i_rd_type = 3'b100;
        #1;
        checks++;
        if ({i_rd_rdy, d_rd_rdy, rd_req} !== 3'b100) begin
            errors++; $display("FAIL ird_grant: got %b want 100", {i_rd_rdy, d_rd_rdy, rd_req});
        end
        @(negedge clk);
        i_rd_req = 1'b0;
        #1;
        checks++;
        if ({rd_req, i_rd_rdy, rd_type, rd_addr} !== {1'b1, 1'b0, 3'b100, 32'h1C00_0010}) begin
            errors++; $display("FAIL ird_req1: got req=%b addr=%h want req=1 addr=1c000010", rd_req, rd_addr);
        end
        @(negedge clk);
        rd_rdy = 1'b1;
        #1;
        checks++;
        if (rd_req !== 1'b1) begin
            errors++; $display("FAIL ird_req2: got %b want 1", rd_req);
        end
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = (b == 3); ret_data = 32'h1111_0000 + b;
            #1;
            if (i_ret_valid === 1'b1) beats++;
            checks++;
            if ({i_ret_last, i_ret_data, rd_req} !== {(b == 3), 32'h1111_0000 + b, 1'b0}) begin
                errors++; $display("FAIL ird_beat%0d: got last=%b data=%h want last=%b data=%h", b, i_ret_last, i_ret_data, (b == 3), 32'h1111_0000 + b);
            end
            checks++;
            if ({d_ret_valid, d_ret_last, d_ret_data} !== 34'd0) begin
                errors++; $display("FAIL ird_dquiet%0d: got v=%b data=%h want 0", b, d_ret_valid, d_ret_data);
            end
        end
        @(negedge clk);
        ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0;
        #1;
        checks++;
        if ({beats, dbg_rd_state} !== {32'd4, 2'd0}) begin
            errors++; $display("FAIL ird_done: got beats=%0d state=%0d want beats=4 state=0", beats, dbg_rd_state);
        end
    endtask

    task automatic test_starvation;
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h1000_0000;
        d_rd_req = 1'b1; d_rd_addr = 32'h2000_0000;
        for (int k = 0; k < 10; k++) begin
            #1;
            checks++;
            if ({i_rd_rdy, d_rd_rdy} !== {exp_i[k], !exp_i[k]}) begin
                errors++; $display("FAIL starve_grant%0d: got i=%b d=%b want i=%b", k, i_rd_rdy, d_rd_rdy, exp_i[k]);
            end
            @(negedge clk);
            rd_rdy = 1'b1;
            #1;
            checks++;
            if (dbg_starve_cnt !== 3'(exp_cnt[k])) begin
                errors++; $display("FAIL starve_cnt%0d: got %0d want %0d", k, dbg_starve_cnt, exp_cnt[k]);
            end
            @(negedge clk);
            rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h100 + k;
            #1;
            checks++;
            if ({i_ret_valid, d_ret_valid} !== {exp_i[k], !exp_i[k]}) begin
                errors++; $display("FAIL starve_route%0d: got i=%b d=%b want i=%b", k, i_ret_valid, d_ret_valid, exp_i[k]);
            end
            @(negedge clk);
            ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0;
        end
        i_rd_req = 1'b0; d_rd_req = 1'b0;
    endtask

    task automatic test_writeback_hazard;
        @(negedge clk);
        d_wr_req = 1'b1; d_wr_addr = 32'h0000_1230; d_wr_type = 3'b100; d_wr_strb = 4'hF;
        d_wr_data = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
        #1;
        checks++;
        if (d_wr_rdy !== 1'b1) begin
            errors++; $display("FAIL wb_accept: got %b want 1", d_wr_rdy);
        end
        @(negedge clk);
        d_wr_req = 1'b0; wr_rdy = 1'b1;
        #1;
        checks++;
        if ({wr_req, d_wr_rdy, wr_addr, wr_strb, wr_data} !==
            {1'b1, 1'b0, 32'h0000_1230, 4'hF, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D}) begin
            errors++; $display("FAIL wb_req: got req=%b addr=%h strb=%h want req=1 addr=00001230 strb=f", wr_req, wr_addr, wr_strb);
        end
        for (int c = 0; c <= 10; c++) begin
            @(negedge clk);
            wr_rdy = 1'b0;
            if (c == 0) begin
                i_rd_req = 1'b1; i_rd_addr = 32'h0000_8000;
                d_rd_req = 1'b1; d_rd_addr = 32'h0000_1238;
            end
            if (c == 1) begin i_rd_req = 1'b0; rd_rdy = 1'b1; end
            if (c == 2) begin rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'h77; end
            if (c == 3) begin ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0; end
            if (c == 10) wr_done = 1'b1;
            #1;
            checks++;
            if (d_rd_rdy !== 1'b0) begin
                errors++; $display("FAIL wb_blocked%0d: got d_rd_rdy=%b want 0", c, d_rd_rdy);
            end
            if (c == 0) begin
                checks++;
                if (i_rd_rdy !== 1'b1) begin
                    errors++; $display("FAIL wb_icache_grant: got %b want 1", i_rd_rdy);
                end
            end
            if (c == 2) begin
                checks++;
                if ({i_ret_valid, i_ret_data} !== {1'b1, 32'h77}) begin
                    errors++; $display("FAIL wb_icache_ret: got v=%b data=%h want v=1 data=77", i_ret_valid, i_ret_data);
                end
            end
        end
        @(negedge clk);
        wr_done = 1'b0;
        #1;
        checks++;
        if ({d_rd_rdy, dbg_wr_state} !== {1'b1, 2'd0}) begin
            errors++; $display("FAIL wb_release: got d_rd_rdy=%b wstate=%0d want 1,0", d_rd_rdy, dbg_wr_state);
        end
        complete_read(32'h88);
    endtask

    task automatic test_same_cycle_hazard;
        @(negedge clk);
        d_wr_req = 1'b1; d_wr_addr = 32'h0000_0040;
        d_rd_req = 1'b1; d_rd_addr = 32'h0000_0044;
        #1;
        checks++;
        if ({d_wr_rdy, d_rd_rdy} !== 2'b10) begin
            errors++; $display("FAIL same_cycle: got wr_rdy=%b rd_rdy=%b want 1,0", d_wr_rdy, d_rd_rdy);
        end
        @(negedge clk);
        d_wr_req = 1'b0; wr_rdy = 1'b1;
        #1;
        checks++;
        if ({wr_req, wr_addr, d_rd_rdy} !== {1'b1, 32'h0000_0040, 1'b0}) begin
            errors++; $display("FAIL same_cycle_buf: got req=%b addr=%h rd_rdy=%b want 1,00000040,0", wr_req, wr_addr, d_rd_rdy);
        end
        @(negedge clk);
        wr_rdy = 1'b0; wr_done = 1'b1;
        #1;
        checks++;
        if (d_rd_rdy !== 1'b0) begin
            errors++; $display("FAIL same_cycle_done: got %b want 0", d_rd_rdy);
        end
        @(negedge clk);
        wr_done = 1'b0;
        #1;
        checks++;
        if (d_rd_rdy !== 1'b1) begin
            errors++; $display("FAIL same_cycle_release: got %b want 1", d_rd_rdy);
        end
        complete_read(32'h99);
    endtask

    task automatic test_back_pressure;
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h2000_0100;
        #1;
        checks++;
        if (i_rd_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_grant: got %b want 1", i_rd_rdy);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            i_rd_req = 1'b0;
            #1;
            checks++;
            if ({rd_req, rd_addr} !== {1'b1, 32'h2000_0100}) begin
                errors++; $display("FAIL bp_rd_hold%0d: got req=%b addr=%h want 1,20000100", c, rd_req, rd_addr);
            end
        end
        @(negedge clk);
        rd_rdy = 1'b1;
        #1;
        checks++;
        if (rd_req !== 1'b1) begin
            errors++; $display("FAIL bp_rd_accept: got %b want 1", rd_req);
        end
        @(negedge clk);
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
        @(negedge clk);
        ret_valid = 1'b0; ret_last = 1'b0;
        d_wr_req = 1'b1; d_wr_addr = 32'h0000_3000;
        #1;
        checks++;
        if (d_wr_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_wr_accept: got %b want 1", d_wr_rdy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            d_wr_req = 1'b0;
            #1;
            checks++;
            if ({wr_req, d_wr_rdy} !== 2'b10) begin
                errors++; $display("FAIL bp_wr_hold%0d: got req=%b d_wr_rdy=%b want 1,0", c, wr_req, d_wr_rdy);
            end
        end
        @(negedge clk);
        wr_rdy = 1'b1;
        @(negedge clk);
        wr_rdy = 1'b0; wr_done = 1'b1;
        #1;
        checks++;
        if ({wr_req, d_wr_rdy} !== 2'b00) begin
            errors++; $display("FAIL bp_wr_wait: got req=%b d_wr_rdy=%b want 0,0", wr_req, d_wr_rdy);
        end
        @(negedge clk);
        wr_done = 1'b0;
        #1;
        checks++;
        if (d_wr_rdy !== 1'b1) begin
            errors++; $display("FAIL bp_wr_free: got %b want 1", d_wr_rdy);
        end
    endtask

    task automatic test_reset_mid_transfer;
        @(negedge clk);
        i_rd_req = 1'b1; i_rd_addr = 32'h0000_5000;
        d_rd_req = 1'b1; d_rd_addr = 32'h0000_6000;
        d_wr_req = 1'b1; d_wr_addr = 32'h0000_7000;
        #1;
        checks++;
        if ({i_rd_rdy, d_rd_rdy, d_wr_rdy} !== 3'b011) begin
            errors++; $display("FAIL rst_setup: got %b want 011", {i_rd_rdy, d_rd_rdy, d_wr_rdy});
        end
        @(negedge clk);
        i_rd_req = 1'b0; d_rd_req = 1'b0; d_wr_req = 1'b0; rd_rdy = 1'b1;
        #1;
        checks++;
        if (dbg_starve_cnt !== 3'd1) begin
            errors++; $display("FAIL rst_starve_pre: got %0d want 1", dbg_starve_cnt);
        end
        @(negedge clk);
        rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b0; ret_data = 32'h1;
        @(negedge clk);
        ret_data = 32'h2;
        #1;
        checks++;
        if ({d_ret_valid, d_ret_data} !== {1'b1, 32'h2}) begin
            errors++; $display("FAIL rst_beat2: got v=%b data=%h want 1,2", d_ret_valid, d_ret_data);
        end
        @(negedge clk);
        ret_valid = 1'b0; ret_data = 32'd0; reset = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if ({i_rd_rdy, d_rd_rdy, d_wr_rdy, rd_req, wr_req, i_ret_valid, d_ret_valid, rd_addr, wr_addr} !== '0) begin
            errors++; $display("FAIL rst_outputs: got ctrl=%b rd_addr=%h wr_addr=%h want 0", {i_rd_rdy, d_rd_rdy, d_wr_rdy, rd_req, wr_req}, rd_addr, wr_addr);
        end
        checks++;
        if ({dbg_rd_state, dbg_wr_state, dbg_starve_cnt} !== 7'd0) begin
            errors++; $display("FAIL rst_state: got %b want 0", {dbg_rd_state, dbg_wr_state, dbg_starve_cnt});
        end
        @(negedge clk);
        reset = 1'b0; i_rd_req = 1'b1; i_rd_addr = 32'h0000_9000;
        #1;
        checks++;
        if (i_rd_rdy !== 1'b1) begin
            errors++; $display("FAIL rst_regrant: got %b want 1", i_rd_rdy);
        end
        complete_read(32'hAA);
    endtask

    initial begin
        reset = 1'b1;
        i_rd_req = 1'b0; i_rd_type = 3'd0; i_rd_addr = 32'd0;
        d_rd_req = 1'b0; d_rd_type = 3'd0; d_rd_addr = 32'd0;
        d_wr_req = 1'b0; d_wr_type = 3'd0; d_wr_addr = 32'd0; d_wr_strb = 4'd0; d_wr_data = 128'd0;
        rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = 32'd0;
        wr_rdy = 1'b0; wr_done = 1'b0;
        test_reset();
        test_icache_read();
        test_starvation();
        test_writeback_hazard();
        test_same_cycle_hazard();
        test_back_pressure();
        test_reset_mid_transfer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cache_axi_arbiter.md
# cache_axi_arbiter

Shares the single cache-line read/write channel of the AXI bridge between the instruction cache and the data cache. Arbitrates read misses (dcache priority with icache anti-starvation), holds one outstanding read, routes returned beats to the owning cache, and buffers one dcache dirty-line writeback. Reads that target the line currently being written back are blocked until the write response arrives.

## Interface
- STARVE_LIMIT, 4: consecutive dcache grants, taken while icache is eligible, before icache is forced to win; legal 1..7.

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- i_rd_req / i_rd_type / i_rd_addr  in  1/3/32  icache read request
- i_rd_rdy  out  1  icache request accepted (1-cycle pulse)
- i_ret_valid / i_ret_last / i_ret_data  out  1/1/32  icache return beats
- d_rd_req / d_rd_type / d_rd_addr  in  1/3/32  dcache read request
- d_rd_rdy  out  1  dcache request accepted (1-cycle pulse)
- d_ret_valid / d_ret_last / d_ret_data  out  1/1/32  dcache return beats
- d_wr_req / d_wr_type / d_wr_addr / d_wr_strb / d_wr_data  in  1/3/32/4/128  dcache writeback
- d_wr_rdy  out  1  writeback buffer free
- rd_req / rd_type / rd_addr  out  1/3/32  bridge read request
- rd_rdy  in  1  bridge accepted read
- ret_valid / ret_last / ret_data  in  1/1/32  bridge read beats
- wr_req / wr_type / wr_addr / wr_strb / wr_data  out  1/3/32/4/128  bridge write request
- wr_rdy  in  1  bridge accepted write
- wr_done  in  1  write response (1-cycle pulse; line is in memory)

## Operation
- Read FSM: R_IDLE -> R_REQ -> R_DATA -> R_IDLE.
- Eligibility: a requester is eligible when its rd_req=1 and it is not hazard-blocked. Hazard: addr[31:4] equals the buffered write line (write FSM not W_IDLE), or equals d_wr_addr[31:4] while d_wr_req && d_wr_rdy in the same cycle.
- Winner selection in R_IDLE: icache wins if it is eligible and (dcache is not eligible, or starve_cnt == STARVE_LIMIT). Otherwise dcache wins.
- On grant (combinational, same cycle):
  - Pulse the winner's *_rd_rdy.
  - Latch owner, type and addr.
  - Go to R_REQ.
- starve_cnt (3 bits):
  - +1 on a dcache grant while icache is eligible; saturates at STARVE_LIMIT.
  - Cleared on an icache grant.
  - Unchanged otherwise.
- R_REQ: rd_req=1 with the latched type/addr. On rd_rdy=1, go to R_DATA.
- R_DATA: ret_valid/ret_last/ret_data are forwarded to the owner only; the non-owner sees valid/last/data = 0. On ret_valid && ret_last, go to R_IDLE. A new grant is possible in the following cycle.
- ret_valid outside R_DATA is ignored.
- Write FSM: W_IDLE -> W_REQ -> W_WAIT -> W_IDLE.
  - d_wr_rdy = (W_IDLE). A transfer occurs when d_wr_req && d_wr_rdy; it latches type/addr/strb/data and goes to W_REQ.
  - W_REQ: wr_req=1 with the latched fields; on wr_rdy go to W_WAIT.
  - W_WAIT: on wr_done go to W_IDLE; the hazard clears in that same cycle's next-state, so a blocked read may be granted in the next cycle.
- The read and write FSMs run independently; a read to an unrelated line proceeds during a writeback.

## Timing
- Reset values: all outputs 0; R_IDLE, W_IDLE, starve_cnt=0, latched fields 0. d_wr_rdy becomes 1 in the first cycle after reset.
- Reset mid-transfer abandons both FSMs; the bridge is reset by the same signal.
- Grant to rd_req: rd_req rises 1 cycle after the *_rd_rdy pulse and stays high until the rd_rdy cycle inclusive.
- Return path: combinational, 0-cycle latency.
- Write accept to wr_req: 1 cycle.
- Only one read is outstanding; upstream *_rd_rdy stays 0 in R_REQ and R_DATA.
- If both caches request in the same cycle, exactly one *_rd_rdy pulses.
- A hazard-blocked requester never receives *_rd_rdy, even when it is the only requester.

## Test plan
- Single icache read, addr 0x1C000010, 4 beats (last on beat 4):
  - i_rd_rdy pulses in cycle 0; rd_req is high from cycle 1 until the rd_rdy cycle.
  - i_ret_valid shows 4 beats; the d_ret_* outputs stay 0 throughout.
- Simultaneous requests, both caches issuing back-to-back reads, STARVE_LIMIT=4: grant order is D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each I grant.
- Writeback to line 0x00001230 is accepted, wr_done is held off 10 cycles, and a dcache read to 0x00001238 is issued:
  - No d_rd_rdy while the write is pending.
  - The read is granted in the cycle after wr_done.
  - An icache read to 0x00008000 issued during the wait is granted without delay.
- Same-cycle hazard: d_wr_req to 0x40 and d_rd_req to 0x44 in the same cycle, with the write FSM in W_IDLE:
  - The write is accepted and the read is blocked.
- Back-pressure:
  - rd_rdy held low 5 cycles: rd_req and rd_addr stay stable for all 5.
  - wr_rdy held low 3 cycles: wr_req stays high and d_wr_rdy stays 0.
- Reset asserted in R_DATA after beat 2: next cycle all outputs are 0, both FSMs are idle and starve_cnt=0; a new icache request is granted normally after reset.
